// File: rtl/icache_fetch_sched.sv
// icache_fetch_sched: converts fetch PCs into cache lookups, issues demand-miss loads, walks a bounded
// next-line prefetch stream after each fill, and tracks outstanding memory tags. Macro: ICACHE_PREFETCH_EN.

module icache_fetch_sched #(
    parameter int ADDR_W     = 16,
    parameter int INDEX_W    = 5,
    parameter int PREF_DEPTH = 4,
    parameter int MAX_OUTST  = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fetch_valid,
    input  logic [ADDR_W-1:0]           fetch_pc,
    input  logic                        flush,
    input  logic                        data_is_miss,
    input  logic                        pref_is_miss,
    input  logic                        cache_is_full,
    input  logic [3:0]                  mem_response,
    input  logic [3:0]                  mem_tag,
    output logic [INDEX_W-1:0]          index_out,
    output logic [ADDR_W-3-INDEX_W-1:0] tag_out,
    output logic                        read_enable,
    output logic [INDEX_W-1:0]          index_pref,
    output logic [ADDR_W-3-INDEX_W-1:0] tag_pref,
    output logic                        read_enable_pref,
    output logic                        icache_do_thing,
    output logic [1:0]                  mem_command,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        fetch_stall
);

    localparam int BLK_W = ADDR_W - 3;
    localparam int TAG_W = BLK_W - INDEX_W;

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_DEMAND_WAIT = 2'd1;
    localparam logic [1:0] S_PREF        = 2'd2;

    localparam logic [1:0]       CMD_NONE  = 2'd0;
    localparam logic [1:0]       CMD_LOAD  = 2'd1;
    localparam logic [4:0]       MAX_CNT   = 5'(MAX_OUTST);
    localparam logic [3:0]       PREF_LAST = 4'(PREF_DEPTH);
    localparam logic [BLK_W-1:0] BLK_ONE   = BLK_W'(1);

    logic [1:0]       state;
    logic [3:0]       pend_tag;
    logic [BLK_W-1:0] dem_blk;
    logic [BLK_W-1:0] pref_blk;
    logic [3:0]       pref_cnt;
    logic [15:1]      outst;

    logic [BLK_W-1:0] fetch_blk;
    logic [4:0]       outst_cnt;
    logic [15:1]      outst_nxt;
    logic             slot_free;
    logic             accepted;
    logic             dem_req;
    logic             pref_try;
    logic             pref_issue;
    logic             pref_step;
    logic             issue_ok;
    logic             cmd_load;
    logic [BLK_W-1:0] cmd_blk;

    // Byte offset within a block never reaches the memory port or the lookup address.
    wire unused_pc_offset = ^fetch_pc[2:0];

    assign fetch_blk = fetch_pc[ADDR_W-1:3];
    assign accepted  = (mem_response != 4'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        outst_cnt = '0;
        for (int t = 1; t < 16; t++) begin
            outst_cnt = outst_cnt + 5'(outst[t]);
        end
    end

    assign slot_free = (outst_cnt < MAX_CNT);

    // A miss on the block we are already waiting for must not re-issue.
    assign dem_req = data_is_miss && slot_free &&
                     !((state == S_DEMAND_WAIT) && (fetch_blk == dem_blk));

    assign pref_try   = (state == S_PREF) && !dem_req && !flush;
    assign pref_issue = pref_try && pref_is_miss && !cache_is_full && slot_free;
    assign pref_step  = pref_try && (!pref_is_miss || (pref_issue && accepted));

    always_comb begin
        cmd_load = 1'b0;
        cmd_blk  = '0;
        issue_ok = 1'b0;
        if (dem_req) begin
            cmd_load = 1'b1;
            cmd_blk  = fetch_blk;
            issue_ok = accepted;
        end else if (pref_issue) begin
            cmd_load = 1'b1;
            cmd_blk  = pref_blk;
            issue_ok = accepted;
        end
    end

    // Returns clear first so that an accept of the same tag in the same cycle leaves it set.
    always_comb begin
        outst_nxt = outst;
        for (int t = 1; t < 16; t++) begin
            if (mem_tag == 4'(t)) outst_nxt[t] = 1'b0;
        end
        for (int t = 1; t < 16; t++) begin
            if (issue_ok && (mem_response == 4'(t))) outst_nxt[t] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= S_IDLE;
            pend_tag <= '0;
            dem_blk  <= '0;
            pref_blk <= '0;
            pref_cnt <= '0;
            outst    <= '0;
        end else begin
            outst <= outst_nxt;
            if (dem_req && accepted) begin
                state    <= S_DEMAND_WAIT;
                pend_tag <= mem_response;
                dem_blk  <= fetch_blk;
                if (flush) pref_cnt <= '0;
            end else if (flush) begin
                state    <= S_IDLE;
                pref_cnt <= '0;
            end else begin
                case (state)
                    S_DEMAND_WAIT: begin
                        if (mem_tag == pend_tag) begin
`ifdef ICACHE_PREFETCH_EN
                            state    <= S_PREF;
                            pref_blk <= dem_blk + BLK_ONE;
                            pref_cnt <= '0;
`else
                            state    <= S_IDLE;
`endif
                        end
                    end
                    S_PREF: begin
                        if (pref_step) begin
                            pref_blk <= pref_blk + BLK_ONE;
                            pref_cnt <= pref_cnt + 4'd1;
                            if (pref_cnt + 4'd1 == PREF_LAST) state <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs are forced low for the whole reset assertion, not just after the next edge.
    always_comb begin
        index_out        = '0;
        tag_out          = '0;
        read_enable      = 1'b0;
        index_pref       = '0;
        tag_pref         = '0;
        read_enable_pref = 1'b0;
        icache_do_thing  = 1'b0;
        mem_command      = CMD_NONE;
        mem_addr         = '0;
        fetch_stall      = 1'b0;
        if (!reset) begin
            index_out       = fetch_blk[INDEX_W-1:0];
            tag_out         = fetch_blk[BLK_W-1:INDEX_W];
            read_enable     = fetch_valid;
            icache_do_thing = issue_ok;
            mem_command     = cmd_load ? CMD_LOAD : CMD_NONE;
            mem_addr        = cmd_load ? {cmd_blk, 3'b000} : '0;
            fetch_stall     = (state == S_DEMAND_WAIT);
`ifdef ICACHE_PREFETCH_EN
            read_enable_pref = (state == S_PREF);
            if (state == S_PREF) begin
                index_pref = pref_blk[INDEX_W-1:0];
                tag_pref   = TAG_W'(pref_blk[BLK_W-1:INDEX_W]);
            end
`endif
        end
    end

endmodule

// File: tb/tb_icache_fetch_sched.sv
// Bench for icache_fetch_sched: directed scenarios plus randomized traffic, all checked cycle by cycle
// against a transaction-level model (mode, remaining stream length, set of busy tags).

module tb_icache_fetch_sched;

    localparam int AW    = 16;
    localparam int IW    = 5;
    localparam int TW    = AW - 3 - IW;
    localparam int DEPTH = 4;
    localparam int MAXO  = 3;
    localparam int NBLK  = 1 << (AW - 3);
`ifdef ICACHE_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic          flush;
    logic          data_is_miss;
    logic          pref_is_miss;
    logic          cache_is_full;
    logic [3:0]    mem_response;
    logic [3:0]    mem_tag;
    logic [IW-1:0] index_out;
    logic [TW-1:0] tag_out;
    logic          read_enable;
    logic [IW-1:0] index_pref;
    logic [TW-1:0] tag_pref;
    logic          read_enable_pref;
    logic          icache_do_thing;
    logic [1:0]    mem_command;
    logic [AW-1:0] mem_addr;
    logic          fetch_stall;

    icache_fetch_sched #(
        .ADDR_W(AW), .INDEX_W(IW), .PREF_DEPTH(DEPTH), .MAX_OUTST(MAXO)
    ) dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .flush(flush), .data_is_miss(data_is_miss), .pref_is_miss(pref_is_miss),
        .cache_is_full(cache_is_full), .mem_response(mem_response), .mem_tag(mem_tag),
        .index_out(index_out), .tag_out(tag_out), .read_enable(read_enable),
        .index_pref(index_pref), .tag_pref(tag_pref), .read_enable_pref(read_enable_pref),
        .icache_do_thing(icache_do_thing), .mem_command(mem_command), .mem_addr(mem_addr),
        .fetch_stall(fetch_stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the sequencer is doing, which tags memory still owes us.
    typedef enum {M_IDLE, M_WAIT, M_PREF} mode_t;
    mode_t m_mode;
    int    m_wait_blk, m_wait_tag, m_next_blk, m_left;
    bit    m_busy[16];
    int    m_fblk;
    bit    m_dem, m_step;
    int    e_re, e_idx, e_tag, e_rep, e_idxp, e_tagp, e_do, e_cmd, e_addr, e_stall;

    function automatic int busy_count();
        int n = 0;
        for (int t = 1; t < 16; t++) n += int'(m_busy[t]);
        return n;
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = '0;
        for (int t = 1; t < 16; t++) v[t-1] = m_busy[t];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_wait_blk = 0; m_wait_tag = 0; m_next_blk = 0; m_left = 0;
        for (int t = 0; t < 16; t++) m_busy[t] = 1'b0;
    endtask

    task automatic predict();
        bit room;
        e_re = 0; e_idx = 0; e_tag = 0; e_rep = 0; e_idxp = 0; e_tagp = 0;
        e_do = 0; e_cmd = 0; e_addr = 0; e_stall = 0;
        m_dem = 1'b0; m_step = 1'b0;
        m_fblk = int'(fetch_pc) / 8;
        if (reset) return;
        e_re    = int'(fetch_valid);
        e_idx   = m_fblk % 32;
        e_tag   = m_fblk / 32;
        e_stall = int'(m_mode == M_WAIT);
        if (PF && m_mode == M_PREF) begin
            e_rep  = 1;
            e_idxp = m_next_blk % 32;
            e_tagp = m_next_blk / 32;
        end
        room  = busy_count() < MAXO;
        m_dem = data_is_miss && room && !(m_mode == M_WAIT && m_fblk == m_wait_blk);
        if (m_dem) begin
            e_cmd = 1; e_addr = m_fblk * 8; e_do = int'(mem_response != 0);
        end else if (PF && m_mode == M_PREF && !flush) begin
            if (!pref_is_miss) begin
                m_step = 1'b1;
            end else if (!cache_is_full && room) begin
                e_cmd = 1; e_addr = m_next_blk * 8; e_do = int'(mem_response != 0);
                m_step = (e_do != 0);
            end
        end
    endtask

    task automatic advance();
        if (reset) begin
            model_reset();
            return;
        end
        if (mem_tag != 0) m_busy[mem_tag] = 1'b0;
        if (e_do != 0) m_busy[mem_response] = 1'b1;
        if (m_dem && mem_response != 0) begin
            m_mode = M_WAIT; m_wait_tag = int'(mem_response); m_wait_blk = m_fblk;
        end else if (flush) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_WAIT && int'(mem_tag) == m_wait_tag) begin
            if (PF) begin
                m_mode = M_PREF; m_next_blk = (m_wait_blk + 1) % NBLK; m_left = DEPTH;
            end else begin
                m_mode = M_IDLE;
            end
        end else if (m_mode == M_PREF && m_step) begin
            m_next_blk = (m_next_blk + 1) % NBLK;
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
        end
    endtask

    task automatic compare_outputs();
        check("read_enable", 32'(read_enable), e_re);
        check("index_out", 32'(index_out), e_idx);
        check("tag_out", 32'(tag_out), e_tag);
        check("read_enable_pref", 32'(read_enable_pref), e_rep);
        check("index_pref", 32'(index_pref), e_idxp);
        check("tag_pref", 32'(tag_pref), e_tagp);
        check("icache_do_thing", 32'(icache_do_thing), e_do);
        check("mem_command", 32'(mem_command), e_cmd);
        check("mem_addr", 32'(mem_addr), e_addr);
        check("fetch_stall", 32'(fetch_stall), e_stall);
    endtask

    task automatic settle();
        #2;
        predict();
        compare_outputs();
    endtask

    task automatic clock_it();
        @(posedge clock);
        advance();
        @(negedge clock);
    endtask

    task automatic drive(input bit fv, input int pc, input bit dmiss, input bit pmiss,
                         input bit full, input int resp, input int tag, input bit fl);
        fetch_valid   = fv;
        fetch_pc      = AW'(pc);
        data_is_miss  = dmiss;
        pref_is_miss  = pmiss;
        cache_is_full = full;
        mem_response  = 4'(resp);
        mem_tag       = 4'(tag);
        flush         = fl;
    endtask

    task automatic random_inputs();
        int r;
        int q[$];
        fetch_valid = ($urandom_range(0, 3) != 0);
        if (m_mode == M_WAIT && $urandom_range(0, 3) == 0)
            fetch_pc = AW'(m_wait_blk * 8 + int'($urandom_range(0, 7)));
        else
            fetch_pc = AW'($urandom);
        data_is_miss  = ($urandom_range(0, 4) == 0);
        pref_is_miss  = 1'($urandom_range(0, 1));
        cache_is_full = ($urandom_range(0, 4) == 0);
        mem_response  = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
        flush         = ($urandom_range(0, 19) == 0);
        r = int'($urandom_range(0, 9));
        mem_tag = 4'd0;
        if (r >= 8) begin
            mem_tag = 4'($urandom_range(1, 15));
        end else if (r >= 5) begin
            if (m_mode == M_WAIT && $urandom_range(0, 2) == 0) begin
                mem_tag = 4'(m_wait_tag);
            end else begin
                for (int t = 1; t < 16; t++) if (m_busy[t]) q.push_back(t);
                if (q.size() > 0) mem_tag = 4'(q[$urandom_range(0, q.size() - 1)]);
            end
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(1, 'h1234, 1, 1, 0, 5, 0, 0);
        settle();
        check("rst_state", 32'(dut.state), 0);
        check("rst_outst", 32'(dut.outst), 0);
        check("rst_pref_cnt", 32'(dut.pref_cnt), 0);
        clock_it();
        reset = 1'b0;

        // Demand miss at 0x0140 accepted with tag 3, then stall until tag 3 returns.
        drive(1, 'h0140, 1, 0, 0, 3, 0, 0); settle();
        check("dmd_cmd", 32'(mem_command), 1);
        check("dmd_addr", 32'(mem_addr), 'h0140);
        check("dmd_do", 32'(icache_do_thing), 1);
        clock_it();
        for (int i = 0; i < 2; i++) begin
            drive(1, 'h0140, 0, 0, 0, 0, 0, 0); settle();
            check("wait_stall", 32'(fetch_stall), 1);
            clock_it();
        end
        drive(1, 'h0140, 0, 0, 0, 0, 3, 0); settle();
        check("fill_stall", 32'(fetch_stall), 1);
        clock_it();

        // Prefetch pattern miss/hit/miss/miss with responses 5,-,6,7.
        drive(1, 'h0140, 0, 1, 0, 5, 0, 0); settle();
        check("pf0_stall", 32'(fetch_stall), 0);
`ifdef ICACHE_PREFETCH_EN
        check("pf0_re", 32'(read_enable_pref), 1);
        check("pf0_idx", 32'(index_pref), 9);
        check("pf0_tag", 32'(tag_pref), 1);
        check("pf0_addr", 32'(mem_addr), 'h0148);
`endif
        clock_it();
        drive(1, 'h0140, 0, 0, 0, 0, 0, 0); settle();
`ifdef ICACHE_PREFETCH_EN
        check("pf1_cmd", 32'(mem_command), 0);
        check("pf1_idx", 32'(index_pref), 10);
`endif
        clock_it();
        drive(1, 'h0140, 0, 1, 0, 6, 0, 0); settle();
`ifdef ICACHE_PREFETCH_EN
        check("pf2_addr", 32'(mem_addr), 'h0158);
`endif
        clock_it();
        drive(1, 'h0140, 0, 1, 0, 7, 0, 0); settle();
`ifdef ICACHE_PREFETCH_EN
        check("pf3_addr", 32'(mem_addr), 'h0160);
`endif
        clock_it();
        drive(1, 'h0140, 0, 1, 0, 0, 0, 0); settle();
        check("pf_done_re", 32'(read_enable_pref), 0);
        check("pf_done_state", 32'(dut.state), 0);
        clock_it();

        // Outstanding limit: demand then prefetch blocked until a tag returns.
        drive(1, 'h0300, 1, 0, 0, 2, 0, 0); settle();
`ifdef ICACHE_PREFETCH_EN
        check("lim_dmd_blocked", 32'(mem_command), 0);
`endif
        clock_it();
        drive(1, 'h0300, 1, 0, 0, 2, 5, 0); settle(); clock_it();
        drive(1, 'h0300, 1, 0, 0, 2, 0, 0); settle(); clock_it();
        drive(1, 'h0300, 0, 0, 0, 0, 2, 0); settle(); clock_it();
        drive(1, 'h0300, 0, 1, 0, 8, 0, 0); settle(); clock_it();
        drive(1, 'h0300, 0, 1, 0, 9, 0, 0); settle();
`ifdef ICACHE_PREFETCH_EN
        check("lim_pf_blocked", 32'(mem_command), 0);
        check("lim_pf_re", 32'(read_enable_pref), 1);
`endif
        clock_it();
        drive(1, 'h0300, 0, 1, 0, 9, 6, 0); settle(); clock_it();
        drive(1, 'h0300, 0, 1, 0, 9, 0, 0); settle();
`ifdef ICACHE_PREFETCH_EN
        check("lim_pf_addr", 32'(mem_addr), 'h0310);
`endif
        clock_it();
        drive(1, 'h0300, 0, 1, 1, 9, 7, 0); settle(); clock_it();

        // Flush together with a demand miss: the demand wins.
        drive(1, 'h0500, 1, 1, 0, 4, 0, 1); settle();
        check("fl_cmd", 32'(mem_command), 1);
        check("fl_addr", 32'(mem_addr), 'h0500);
        check("fl_do", 32'(icache_do_thing), 1);
        clock_it();
        drive(1, 'h0500, 0, 0, 0, 0, 0, 0); settle();
        check("fl_stall", 32'(fetch_stall), 1);
        check("fl_pref_cnt", 32'(dut.pref_cnt), 0);
        check("fl_state", 32'(dut.state), 1);
        clock_it();

        // Rejected demand retried at the same address, accepted on the third try.
        drive(1, 'h0500, 0, 0, 0, 0, 8, 0); settle(); clock_it();
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h0600, 1, 0, 0, (i == 2) ? 11 : 0, 0, 0); settle();
            check("retry_cmd", 32'(mem_command), 1);
            check("retry_addr", 32'(mem_addr), 'h0600);
            check("retry_do", 32'(icache_do_thing), (i == 2) ? 1 : 0);
            clock_it();
        end
        drive(1, 'h0600, 0, 0, 0, 0, 11, 0); settle(); clock_it();

        // Asynchronous reset in the middle of a stream, then a stale return.
        reset = 1'b1;
        drive(1, 'h0777, 1, 1, 0, 5, 0, 0); settle();
        check("mid_rst_state", 32'(dut.state), 0);
        check("mid_rst_outst", 32'(dut.outst), 0);
        clock_it();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 9, 0); settle(); clock_it();
        check("late_ret_outst", 32'(dut.outst), 0);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            random_inputs();
            settle();
            clock_it();
            #1;
            check("outst_vec", 32'(dut.outst), busy_vec());
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_fetch_sched.md
# icache_fetch_sched

Sequencer between the fetch stage, the instruction-cache storage array and the unified memory port. It turns fetch-stage PCs into index/tag lookups and issues the memory load for a demand miss. After each demand fill it walks a bounded next-line prefetch stream. It also tracks outstanding memory tags, asserting the cache's allocate strobe only on cycles when memory accepts a load.

## Interface
- `ADDR_W`, 16: byte-address width of the memory bus.
- `INDEX_W`, 5: cache index width; tag width is `ADDR_W-3-INDEX_W` (8-byte blocks).
- `PREF_DEPTH`, 4: blocks prefetched after each demand fill (1..15).
- `MAX_OUTST`, 8: maximum memory loads in flight (1..15).

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetch_valid` in 1: fetch stage presents a PC.
- `fetch_pc` in ADDR_W: fetch byte address.
- `flush` in 1: branch redirect; abandons the prefetch stream.
- `data_is_miss` in 1: cache reports demand miss for the current lookup.
- `pref_is_miss` in 1: cache reports miss for the current prefetch lookup.
- `cache_is_full` in 1: victim way still awaiting a fill.
- `mem_response` in 4: memory accept tag; 0 = rejected.
- `mem_tag` in 4: tag of data returning this cycle; 0 = none.
- `index_out`/`tag_out` out INDEX_W/tag: demand lookup address.
- `read_enable` out 1: demand lookup valid.
- `index_pref`/`tag_pref` out INDEX_W/tag: prefetch lookup address.
- `read_enable_pref` out 1: prefetch lookup valid.
- `icache_do_thing` out 1: cache may allocate this cycle.
- `mem_command` out 2: 0 = none, 1 = load.
- `mem_addr` out ADDR_W: block-aligned load address (low 3 bits 0).
- `fetch_stall` out 1: fetch must hold its PC.

## Operation
- States: IDLE, DEMAND_WAIT, PREF. Registers:
  - `pend_tag` (4b)
  - `pref_blk` (ADDR_W-3)
  - `pref_cnt`
  - `outst` (15-bit one-hot-per-tag vector)
- `index_out`/`tag_out` are always sliced from `fetch_pc[ADDR_W-1:3]`. `read_enable` = `fetch_valid`.
- Demand issue occurs in any state when `data_is_miss`, outstanding count < MAX_OUTST, and not (DEMAND_WAIT with the same block):
  - drive `mem_command`=1, `mem_addr` = block of `fetch_pc`.
  - If `mem_response`≠0: assert `icache_do_thing`, set `outst[mem_response]`, capture `pend_tag`, next state DEMAND_WAIT.
  - If `mem_response`=0: retry the following cycle.
- Demand has priority over prefetch in the same cycle.
- DEMAND_WAIT: `fetch_stall`=1.
  - When `mem_tag`==`pend_tag`: go to PREF with `pref_blk` = demand block+1 and `pref_cnt`=0.
- PREF: `read_enable_pref`=1 with address from `pref_blk`.
  - `pref_is_miss`=0: advance `pref_blk`, increment `pref_cnt`; no memory traffic.
  - `pref_is_miss`=1, `!cache_is_full`, slot free: issue load. If accepted, assert `icache_do_thing`, set `outst` bit, and advance. If rejected or `cache_is_full`, hold.
  - When `pref_cnt`==PREF_DEPTH: go to IDLE.
- Any nonzero `mem_tag` clears its `outst` bit.
  - Issue and clear on the same tag in the same cycle: set wins.
- `flush`: next state IDLE and `pref_cnt`=0; `outst` is kept.
  - `flush` together with a demand issue: the issue proceeds, giving DEMAND_WAIT.
- Block addresses wrap modulo 2^(ADDR_W-3).

## Timing
- Reset values: state IDLE, all registers and outputs 0.
- Reset mid-operation clears `outst`; late memory returns are ignored.
- Lookup and memory outputs are combinational from state and inputs. `icache_do_thing` is high only in the issue cycle.
- Demand miss to issue: 0 cycles.
- Fill to first prefetch lookup: 1 cycle.
- Each prefetch step takes 1 cycle when accepted or a hit.

## Configuration
- `ICACHE_PREFETCH_EN` defined: PREF state and prefetch outputs are active as described.
- Undefined: DEMAND_WAIT returns to IDLE on fill. `read_enable_pref`, `index_pref` and `tag_pref` are tied 0; PREF_DEPTH is ignored.

## Test plan
- Reset asserted mid-PREF with `outst`≠0 → all outputs 0 immediately; state IDLE; `outst`=0.
- Miss at `fetch_pc`=0x0140, `mem_response`=3 → `mem_addr`=0x0140 and `icache_do_thing`=1 that cycle; `fetch_stall`=1 until `mem_tag`=3; next cycle `read_enable_pref`=1 for block 0x0148.
- `pref_is_miss` pattern 1,0,1,1 with PREF_DEPTH=4 and response 5,–,6,7 → three loads at 0x0148, 0x0158, 0x0160, then IDLE.
- `mem_response`=0 for 2 cycles on a demand miss → command held at the same address; accepted on the 3rd cycle.
- MAX_OUTST=2 with two loads outstanding and a prefetch miss → no command until one `mem_tag` returns.
- `flush` and `data_is_miss` in the same PREF cycle → demand issued; state DEMAND_WAIT; `pref_cnt`=0.
